// File: rtl/systolic_out_reader.sv
// Drains a block of rows from the systolic output buffer and streams them
// downstream through a 2-entry FIFO with valid/ready handshaking.
module systolic_out_reader #(
    parameter int DATAWIDTH_output = 32,
    parameter int N_SIZE           = 32,
    parameter int ADDR_WIDTH       = 10,
    parameter int DEPTH            = 543
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [ADDR_WIDTH-1:0]              num_rows,
    output logic [ADDR_WIDTH-1:0]              rd_addr_outbuffer,
    input  logic [DATAWIDTH_output*N_SIZE-1:0] buf_data,
    output logic [DATAWIDTH_output*N_SIZE-1:0] out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic                               busy,
    output logic                               done
);

    localparam int ROW_W = DATAWIDTH_output * N_SIZE;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] num_q;
    logic [ADDR_WIDTH-1:0] issued;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  in_flight;
    logic                  in_flight_last;

    logic [ROW_W-1:0]      fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic                  pop;
    logic                  accept_start;
    logic                  issue;
    logic                  issue_last;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [ADDR_WIDTH:0]   addr_sum;
    logic [ADDR_WIDTH-1:0] addr_wrapped;
    logic [2:0]            occ;

    assign pop          = out_valid && out_ready;
    assign accept_start = (state == S_IDLE) && start;
    // Slots committed for next cycle: held rows plus the row returning from the buffer.
    assign occ          = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};

    // The first read goes out in the start cycle itself so rows appear two cycles later.
    always_comb begin
        issue      = 1'b0;
        issue_addr = next_addr;
        issue_last = 1'b0;
        if (accept_start) begin
            issue      = (num_rows != '0);
            issue_addr = base_addr;
            issue_last = (num_rows == ONE);
        end else if (state == S_RUN) begin
            issue      = (issued < num_q) && (occ < 3'd2);
            issue_last = (issued == num_q - ONE);
        end
    end

    always_comb begin
        addr_sum     = {1'b0, issue_addr} + {{ADDR_WIDTH{1'b0}}, 1'b1};
        addr_wrapped = (addr_sum >= DEPTH_W) ? ADDR_WIDTH'(addr_sum - DEPTH_W)
                                             : ADDR_WIDTH'(addr_sum);
    end

    assign rd_addr_outbuffer = issue ? issue_addr : last_addr;

    assign out_valid = (count != 2'd0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last  = out_valid && fifo_last[rd_ptr];
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FINISH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            num_q          <= '0;
            issued         <= '0;
            next_addr      <= '0;
            last_addr      <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            fifo_data[0]   <= '0;
            fifo_data[1]   <= '0;
            fifo_last      <= 2'b00;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            count          <= 2'd0;
        end else begin
            if (issue) begin
                last_addr <= issue_addr;
                next_addr <= addr_wrapped;
            end
            in_flight      <= issue;
            in_flight_last <= issue && issue_last;

            // Buffer data is valid exactly one cycle after its address.
            if (in_flight) begin
                fifo_data[wr_ptr] <= buf_data;
                fifo_last[wr_ptr] <= in_flight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, in_flight} - {1'b0, pop};

            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_q  <= num_rows;
                        issued <= (num_rows != '0) ? ONE : '0;
                        state  <= (num_rows != '0) ? S_RUN : S_FINISH;
                    end
                end
                S_RUN: begin
                    if (issue)
                        issued <= issued + ONE;
                    if (pop && out_last)
                        state <= S_FINISH;
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_out_reader.sv
// Bench for systolic_out_reader: table of block requests plus random blocks,
// checked against a queue of expected rows derived from (base+k) mod DEPTH.
module tb_systolic_out_reader;

    localparam int DW    = 32;
    localparam int NS    = 4;
    localparam int AW    = 10;
    localparam int DEPTH = 543;
    localparam int RW    = DW * NS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_rows;
    logic [AW-1:0] rd_addr_outbuffer;
    logic [RW-1:0] buf_data = '0;
    logic [RW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;
    int model_last_addr = 0;

    always #5 clk = ~clk;

    systolic_out_reader #(
        .DATAWIDTH_output(DW), .N_SIZE(NS), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .rd_addr_outbuffer(rd_addr_outbuffer),
        .buf_data(buf_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    function automatic logic [RW-1:0] row_of(input int a);
        logic [RW-1:0] r;
        for (int i = 0; i < NS; i++)
            r[i*DW +: DW] = 32'hC0DE_0000 ^ 32'(a << 4) ^ 32'(i);
        return r;
    endfunction

    // Output buffer model: synchronous read, one cycle latency.
    always @(posedge clk) buf_data <= row_of(int'(rd_addr_outbuffer));

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int base;
        int num;
        int pct;        // out_ready probability in percent
        int exp_first;  // cycle of first out_valid after start, -1 = unchecked
        int exp_done;   // cycle of done after start, -1 = unchecked
        bit mid_start;  // pulse a second start mid-block
        bit idle_chk;   // observe idle cycles afterwards (else next block is back-to-back)
    } vec_t;

    // Called at posedge+1; returns at posedge+1 of the cycle after FINISH.
    task automatic run_block(input vec_t v);
        logic [RW-1:0] expq[$];
        logic [RW-1:0] pd;
        logic          pl;
        logic          stalled;
        int first, donec, busy_bad, addr_bad, idle_bad;
        stalled = 1'b0; pd = '0; pl = 1'b0;
        first = -1; donec = -1; busy_bad = 0; addr_bad = 0; idle_bad = 0;
        for (int k = 0; k < v.num; k++)
            expq.push_back(row_of((v.base + k) % DEPTH));
        for (int cyc = 0; cyc < 300 && donec < 0; cyc++) begin
            start     = (cyc == 0) || (v.mid_start && cyc == 3);
            base_addr = (cyc == 0) ? AW'(v.base) : (v.mid_start ? AW'(300) : base_addr);
            num_rows  = (cyc == 0) ? AW'(v.num)  : (v.mid_start ? AW'(3)   : num_rows);
            out_ready = ($urandom_range(99) < v.pct);
            @(negedge clk);
            if (v.num == 0 && rd_addr_outbuffer != AW'(model_last_addr)) addr_bad++;
            if (cyc > 0 && !busy) busy_bad++;
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (stalled) begin
                    chk("stall_data", out_data, pd);
                    chk("stall_last", out_last, pl);
                end
                if (out_ready) begin
                    if (expq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL extra_row: got %h expected none", out_data);
                    end else begin
                        chk("row_data", out_data, expq[0]);
                        chk("row_last", out_last, expq.size() == 1);
                        void'(expq.pop_front());
                    end
                end
                stalled = !out_ready;
                pd = out_data;
                pl = out_last;
            end else begin
                if (stalled) begin
                    tests++; fails++;
                    $display("FAIL stall_drop: got out_valid 0 expected 1");
                end
                stalled = 1'b0;
            end
            if (done) donec = cyc;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk_int("rows_left", expq.size(), 0);
        chk_int("done_seen", int'(donec >= 0), 1);
        chk_int("busy_during", busy_bad, 0);
        if (v.exp_first >= 0) chk_int("first_valid", first, v.exp_first);
        if (v.exp_done >= 0)  chk_int("done_cycle", donec, v.exp_done);
        if (v.num == 0) begin
            chk_int("zero_no_valid", first, -1);
            chk_int("zero_no_read", addr_bad, 0);
        end
        if (v.num > 0) model_last_addr = (v.base + v.num - 1) % DEPTH;
        if (v.idle_chk) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (busy || done || out_valid) idle_bad++;
                if (rd_addr_outbuffer != AW'(model_last_addr)) idle_bad++;
                @(posedge clk); #1;
            end
            chk_int("idle_after", idle_bad, 0);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int   got;
        int   after_rst_bad;
        vec_t rv;
        vecs[0] = '{5,   4, 100, 2,  6, 1'b0, 1'b1};  // streaming
        vecs[1] = '{541, 4, 100, 2,  6, 1'b0, 1'b0};  // wrap, then back-to-back
        vecs[2] = '{0,   0, 100, -1, 1, 1'b0, 1'b1};  // zero rows
        vecs[3] = '{10,  6, 50,  -1, -1, 1'b0, 1'b1}; // backpressure
        vecs[4] = '{30,  6, 100, 2,  8, 1'b1, 1'b1};  // ignored mid-block start
        vecs[5] = '{542, 1, 100, 2,  3, 1'b0, 1'b0};  // single row at top address
        vecs[6] = '{100, 9, 35,  -1, -1, 1'b0, 1'b1}; // heavy backpressure

        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", rd_addr_outbuffer, '0);
        chk("rst_data", out_data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_block(vecs[i]);

        for (int r = 0; r < 6; r++) begin
            rv = '{int'($urandom_range(DEPTH-1)), int'($urandom_range(10)),
                   int'($urandom_range(100, 20)), -1, -1, 1'b0, r[0]};
            run_block(rv);
        end

        // Reset in the middle of a 6-row block after two rows are accepted.
        start = 1'b1; base_addr = AW'(20); num_rows = AW'(6); out_ready = 1'b1; got = 0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) got++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk_int("midrst_rows_before", got, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_last", out_last, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_addr", rd_addr_outbuffer, '0);
        chk("midrst_data", out_data, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_last_addr = 0;
        after_rst_bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || busy || out_valid) after_rst_bad++;
            @(posedge clk); #1;
        end
        chk_int("midrst_quiet", after_rst_bad, 0);
        run_block('{0, 2, 100, 2, 4, 1'b0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_out_reader.md
SYSTOLIC_OUT_READER -- requirements
Module: systolic_out_reader

Interface
REQ-001 SHALL have parameter DATAWIDTH_output, default 32, bit width of one accumulated result element.
REQ-002 SHALL have parameter N_SIZE, default 32, result elements per buffer row.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, output-buffer address width.
REQ-004 SHALL have parameter DEPTH, default 543, output-buffer row count; legal addresses are 0..DEPTH-1.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-007 SHALL have port start  input  1  single-cycle request to drain a block of rows.
REQ-008 SHALL have port base_addr  input  ADDR_WIDTH  first row address, sampled with start.
REQ-009 SHALL have port num_rows  input  ADDR_WIDTH  rows to drain, sampled with start.
REQ-010 SHALL have port rd_addr_outbuffer  output  ADDR_WIDTH  read address to the output buffer.
REQ-011 SHALL have port buf_data  input  DATAWIDTH_output*N_SIZE  output-buffer read data, valid one cycle after address.
REQ-012 SHALL have port out_data  output  DATAWIDTH_output*N_SIZE  streamed row.
REQ-013 SHALL have port out_valid  output  1  out_data valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts row.
REQ-015 SHALL have port out_last  output  1  high with the final row of a block.
REQ-016 SHALL have port busy  output  1  high from accepted start until done.
REQ-017 SHALL have port done  output  1  one-cycle pulse at block completion.

Function
REQ-018 SHALL implement FSM IDLE -> RUN -> FINISH -> IDLE.
REQ-019 SHALL accept start only in IDLE; start in RUN/FINISH is ignored, sampled values unchanged.
REQ-020 SHALL, on accepted start with num_rows>0, latch base_addr/num_rows, clear issue/accept counters, enter RUN, busy=1 next cycle.
REQ-021 SHALL, on accepted start with num_rows=0, go directly to FINISH: no read, no out_valid, done pulses the cycle after start.
REQ-022 SHALL compute row k address as base_addr+k, minus DEPTH when sum >= DEPTH (wrap); sum computed ADDR_WIDTH+1 bits wide.
REQ-023 SHALL treat buffer read latency as exactly 1 cycle: data for address issued in cycle t is captured from buf_data at cycle t+1.
REQ-024 SHALL hold rows in an internal 2-entry FIFO feeding out_data/out_valid (head entry).
REQ-025 SHALL issue a read in a RUN cycle only if issued<num_rows and (held + in_flight - pop) < 2, pop = out_valid&&out_ready.
REQ-026 SHALL sustain one row per cycle when out_ready stays high (first out_valid 2 cycles after start).
REQ-027 SHALL keep out_data, out_last stable and out_valid high while out_valid && !out_ready.
REQ-028 SHALL never drop, duplicate or reorder rows; rows emerge in address order k=0..num_rows-1.
REQ-029 SHALL assert out_last exactly with row num_rows-1.
REQ-030 SHALL enter FINISH on the cycle the last row is accepted; FINISH lasts one cycle with done=1, busy=1; then IDLE, busy=0.
REQ-031 SHALL allow start in the cycle after FINISH (back-to-back blocks).
REQ-032 SHALL drive rd_addr_outbuffer = last issued address when not issuing (no glitching to undefined).

Reset
REQ-033 SHALL, when rst_n=0 at a clock edge, force IDLE, empty FIFO, clear in-flight flag and counters, and drive out_valid=0, out_last=0, busy=0, done=0, rd_addr_outbuffer=0, out_data=0.
REQ-034 SHALL abandon any block in progress on reset, with no done pulse; first start after reset release is accepted normally.

Verification
REQ-035 SHALL verify streaming: N_SIZE=4, base=5, num=4, out_ready=1 -> rows of addrs 5,6,7,8 on 4 consecutive cycles from start+2, out_last with addr 8, done one cycle after.
REQ-036 SHALL verify backpressure: num=6, out_ready random 50% -> 6 rows in order, data stable while stalled, no FIFO overflow (held+in_flight<=2).
REQ-037 SHALL verify wrap: DEPTH=543, base=541, num=4 -> addresses 541,542,0,1.
REQ-038 SHALL verify zero rows: num=0 -> no read, out_valid never 1, done one cycle after start.
REQ-039 SHALL verify ignored start: start pulse mid-RUN with new base -> current block completes unchanged, no second block.
REQ-040 SHALL verify mid-block reset: rst_n=0 after 2 of 6 rows -> all outputs 0 next cycle, no done; new start base=0 num=2 drains correctly.
